// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RISC-V immediate generator (I/S/B/U/J/R decode, sign-extended to XLEN) behind a valid/ready output stage.
// Latency: 1 cycle. An accept at edge N presents imm/fmt/illegal with out_valid=1 after edge N.
// Backpressure: SKID=1 parks one extra word in a skid entry and in_ready comes from a flop. SKID=0 has no skid entry and in_ready = !out_valid || out_ready.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   instruction handshake, instr is the 32-bit instruction word
//   out_valid/out_ready result handshake
//   imm                 sign-extended immediate (XLEN bits)
//   fmt                 0=R 1=I 2=S 3=B 4=U 5=J 7=illegal
//   illegal             opcode not recognised for this XLEN
//   illegal_cnt         saturating count of accepted illegal words
module imm_gen_pipe #(
   parameter int XLEN = 64,   // 32 or 64
   parameter int SKID = 1     // 1: two-entry skid buffer, 0: single register
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instr,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] imm,
   output logic [2:0]      fmt,
   output logic            illegal,
   output logic [7:0]      illegal_cnt
);

   localparam bit RV64 = (XLEN == 64);

   localparam logic [2:0] FMT_R   = 3'd0;
   localparam logic [2:0] FMT_I   = 3'd1;
   localparam logic [2:0] FMT_S   = 3'd2;
   localparam logic [2:0] FMT_B   = 3'd3;
   localparam logic [2:0] FMT_U   = 3'd4;
   localparam logic [2:0] FMT_J   = 3'd5;
   localparam logic [2:0] FMT_ILL = 3'd7;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_REG32  = 7'b0111011;

   // One decoded result, as held in the output register and the skid entry.
   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [2:0]      fmt;
      logic            illegal;
   } res_t;

   typedef enum logic {
      EMPTY_SKID = 1'b0,
      FULL_SKID  = 1'b1
   } state_t;

   // ------------------------------------------------------------------
   // Combinational decode
   // ------------------------------------------------------------------
   logic        [6:0]      opcode;
   logic signed [31:0]     imm32;
   logic signed [XLEN-1:0] imm_sext;
   logic        [2:0]      dec_fmt;
   logic                   dec_ill;
   res_t                   dec;

   always_comb begin
      opcode  = instr[6:0];
      imm32   = '0;
      dec_fmt = FMT_ILL;
      dec_ill = 1'b1;
      case (opcode)
         OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: begin
            imm32   = {{20{instr[31]}}, instr[31:20]};
            dec_fmt = FMT_I;
            dec_ill = 1'b0;
         end
         OP_IMM32: begin
            if (RV64) begin
               imm32   = {{20{instr[31]}}, instr[31:20]};
               dec_fmt = FMT_I;
               dec_ill = 1'b0;
            end
         end
         OP_STORE: begin
            imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            dec_fmt = FMT_S;
            dec_ill = 1'b0;
         end
         OP_BRANCH: begin
            imm32   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            dec_fmt = FMT_B;
            dec_ill = 1'b0;
         end
         OP_LUI, OP_AUIPC: begin
            imm32   = {instr[31:12], 12'b0};
            dec_fmt = FMT_U;
            dec_ill = 1'b0;
         end
         OP_JAL: begin
            imm32   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            dec_fmt = FMT_J;
            dec_ill = 1'b0;
         end
         OP_REG: begin
            dec_fmt = FMT_R;
            dec_ill = 1'b0;
         end
         OP_REG32: begin
            if (RV64) begin
               dec_fmt = FMT_R;
               dec_ill = 1'b0;
            end
         end
         default: begin
            imm32   = '0;
            dec_fmt = FMT_ILL;
            dec_ill = 1'b1;
         end
      endcase
   end

   // Signed-to-wider-signed assignment replicates bit 31 up to XLEN.
   // R-type and illegal leave imm32 at zero, so every bit of imm is driven.
   always_comb begin
      imm_sext    = imm32;
      dec.imm     = imm_sext;
      dec.fmt     = dec_fmt;
      dec.illegal = dec_ill;
   end

   // ------------------------------------------------------------------
   // Output stage
   // ------------------------------------------------------------------
   state_t     state_q, state_d;
   res_t       out_q, out_d;
   res_t       skid_q, skid_d;
   logic       out_vld_q, out_vld_d;
   logic [7:0] ill_cnt_q, ill_cnt_d;
   logic       acc;

   // State register (all flops of the block)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= EMPTY_SKID;
         out_q     <= '0;
         skid_q    <= '0;
         out_vld_q <= 1'b0;
         ill_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         out_q     <= out_d;
         skid_q    <= skid_d;
         out_vld_q <= out_vld_d;
         ill_cnt_q <= ill_cnt_d;
      end
   end

   // Output decode: in_ready.
   // With the skid buffer, in_ready depends only on the state flop, which
   // keeps out_ready off the input timing path. Without it, ready is the
   // usual pipeline-register term.
   always_comb begin
      if (SKID != 0) begin
         in_ready = (state_q == EMPTY_SKID);
      end else begin
         in_ready = !out_vld_q || out_ready;
      end
   end

   assign acc = in_valid && in_ready;

   // Next-state and datapath
   always_comb begin
      state_d   = state_q;
      out_d     = out_q;
      skid_d    = skid_q;
      out_vld_d = out_vld_q;
      case (state_q)
         EMPTY_SKID: begin
            if (acc) begin
               if (!out_vld_q || out_ready) begin
                  // The output register is free or being drained this edge.
                  out_d     = dec;
                  out_vld_d = 1'b1;
               end else if (SKID != 0) begin
                  // The output is stalled, so park the word in the skid entry.
                  skid_d  = dec;
                  state_d = FULL_SKID;
               end
            end else if (out_vld_q && out_ready) begin
               out_vld_d = 1'b0;
            end
         end
         FULL_SKID: begin
            // Both entries are valid. Shift skid into output on drain; out_valid stays 1.
            if (out_ready) begin
               out_d   = skid_q;
               state_d = EMPTY_SKID;
            end
         end
         default: begin
            state_d = EMPTY_SKID;
         end
      endcase
   end

   // Saturating illegal counter, stepped on accept so stalls cannot double count.
   always_comb begin
      ill_cnt_d = ill_cnt_q;
      if (acc && dec.illegal && (ill_cnt_q != 8'hFF)) begin
         ill_cnt_d = ill_cnt_q + 8'd1;
      end
   end

   assign out_valid   = out_vld_q;
   assign imm         = out_q.imm;
   assign fmt         = out_q.fmt;
   assign illegal     = out_q.illegal;
   assign illegal_cnt = ill_cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed bench for imm_gen_pipe.
// u_a: XLEN=64 SKID=1, u_b: XLEN=32 SKID=1, u_c: XLEN=64 SKID=0.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_imm_gen_pipe;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // u_a
   logic        a_iv, a_ir, a_ov, a_or, a_ill;
   logic [31:0] a_instr;
   logic [63:0] a_imm;
   logic [2:0]  a_fmt;
   logic [7:0]  a_cnt;
   // u_b
   logic        b_iv, b_ir, b_ov, b_or, b_ill;
   logic [31:0] b_instr;
   logic [31:0] b_imm;
   logic [2:0]  b_fmt;
   logic [7:0]  b_cnt;
   // u_c
   logic        c_iv, c_ir, c_ov, c_or, c_ill;
   logic [31:0] c_instr;
   logic [63:0] c_imm;
   logic [2:0]  c_fmt;
   logic [7:0]  c_cnt;

   imm_gen_pipe #(.XLEN(64), .SKID(1)) u_a (
      .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .instr(a_instr),
      .out_valid(a_ov), .out_ready(a_or), .imm(a_imm), .fmt(a_fmt),
      .illegal(a_ill), .illegal_cnt(a_cnt)
   );

   imm_gen_pipe #(.XLEN(32), .SKID(1)) u_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .instr(b_instr),
      .out_valid(b_ov), .out_ready(b_or), .imm(b_imm), .fmt(b_fmt),
      .illegal(b_ill), .illegal_cnt(b_cnt)
   );

   imm_gen_pipe #(.XLEN(64), .SKID(0)) u_c (
      .clk(clk), .rst_n(rst_n), .in_valid(c_iv), .in_ready(c_ir), .instr(c_instr),
      .out_valid(c_ov), .out_ready(c_or), .imm(c_imm), .fmt(c_fmt),
      .illegal(c_ill), .illegal_cnt(c_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL rst_a_ov: got %b want 0", a_ov); end
      checks++; if (a_imm !== 64'h0) begin errors++; $display("FAIL rst_a_imm: got %h want 0", a_imm); end
      checks++; if (a_fmt !== 3'd0) begin errors++; $display("FAIL rst_a_fmt: got %0d want 0", a_fmt); end
      checks++; if (a_ill !== 1'b0) begin errors++; $display("FAIL rst_a_ill: got %b want 0", a_ill); end
      checks++; if (a_cnt !== 8'd0) begin errors++; $display("FAIL rst_a_cnt: got %0d want 0", a_cnt); end
      checks++; if (a_ir !== 1'b1) begin errors++; $display("FAIL rst_a_ir: got %b want 1", a_ir); end
      checks++; if (b_ir !== 1'b1) begin errors++; $display("FAIL rst_b_ir: got %b want 1", b_ir); end
      checks++; if (c_ir !== 1'b1) begin errors++; $display("FAIL rst_c_ir: got %b want 1", c_ir); end
      checks++; if (c_ov !== 1'b0) begin errors++; $display("FAIL rst_c_ov: got %b want 0", c_ov); end
   endtask

   task automatic test_formats();
      logic [31:0] ins  [12];
      logic [63:0] eimm [12];
      logic [2:0]  efmt [12];
      logic        eill [12];
      ins  = '{32'hFF812083, 32'h00513823, 32'hFE000EE3, 32'h800000B7,
               32'h001000EF, 32'h0000003B, 32'h0010009B, 32'hFFFFFFFF,
               32'hFFF00067, 32'h00C58533, 32'h12345017, 32'h00000073};
      eimm = '{64'hFFFFFFFFFFFFFFF8, 64'h10, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFF80000000,
               64'h800, 64'h0, 64'h1, 64'h0,
               64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0000000012345000, 64'h0};
      efmt = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1, 3'd7, 3'd1, 3'd0, 3'd4, 3'd1};
      eill = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      a_or = 1'b1;
      for (int i = 0; i < 12; i++) begin
         a_iv    = 1'b1;
         a_instr = ins[i];
         tick();
         checks++; if (a_ov !== 1'b1) begin errors++; $display("FAIL fmt_ov[%0d]: got %b want 1", i, a_ov); end
         checks++; if (a_imm !== eimm[i]) begin errors++; $display("FAIL fmt_imm[%0d]: got %h want %h", i, a_imm, eimm[i]); end
         checks++; if (a_fmt !== efmt[i]) begin errors++; $display("FAIL fmt_fmt[%0d]: got %0d want %0d", i, a_fmt, efmt[i]); end
         checks++; if (a_ill !== eill[i]) begin errors++; $display("FAIL fmt_ill[%0d]: got %b want %b", i, a_ill, eill[i]); end
      end
      a_iv = 1'b0;
      tick();
      checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL fmt_drain_ov: got %b want 0", a_ov); end
      checks++; if (a_cnt !== 8'd1) begin errors++; $display("FAIL fmt_cnt: got %0d want 1", a_cnt); end
   endtask

   task automatic test_illegal32();
      logic [31:0] ins  [4];
      logic [31:0] eimm [4];
      logic [2:0]  efmt [4];
      logic        eill [4];
      ins  = '{32'h0000001B, 32'hFFFFFFBB, 32'h800000B7, 32'hFF812083};
      eimm = '{32'h0, 32'h0, 32'h80000000, 32'hFFFFFFF8};
      efmt = '{3'd7, 3'd7, 3'd4, 3'd1};
      eill = '{1'b1, 1'b1, 1'b0, 1'b0};
      b_or = 1'b1;
      for (int i = 0; i < 4; i++) begin
         b_iv    = 1'b1;
         b_instr = ins[i];
         tick();
         checks++; if (b_imm !== eimm[i]) begin errors++; $display("FAIL x32_imm[%0d]: got %h want %h", i, b_imm, eimm[i]); end
         checks++; if (b_fmt !== efmt[i]) begin errors++; $display("FAIL x32_fmt[%0d]: got %0d want %0d", i, b_fmt, efmt[i]); end
         checks++; if (b_ill !== eill[i]) begin errors++; $display("FAIL x32_ill[%0d]: got %b want %b", i, b_ill, eill[i]); end
      end
      b_iv = 1'b0;
      tick();
      checks++; if (b_cnt !== 8'd2) begin errors++; $display("FAIL x32_cnt2: got %0d want 2", b_cnt); end
      // 300 illegal words back to back; counter starts at 2.
      for (int i = 0; i < 300; i++) begin
         b_iv    = 1'b1;
         b_instr = 32'h0000001B;
         tick();
         if (i == 251) begin
            checks++; if (b_cnt !== 8'd254) begin errors++; $display("FAIL sat_254: got %0d want 254", b_cnt); end
         end
         if (i == 252) begin
            checks++; if (b_cnt !== 8'd255) begin errors++; $display("FAIL sat_255: got %0d want 255", b_cnt); end
         end
      end
      b_iv = 1'b0;
      tick();
      checks++; if (b_cnt !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d want 255", b_cnt); end
   endtask

   task automatic test_skid();
      a_or    = 1'b0;
      a_iv    = 1'b1;
      a_instr = 32'h00100013;   // A: addi imm=1
      #1;
      checks++; if (a_ir !== 1'b1) begin errors++; $display("FAIL skid_ir0: got %b want 1", a_ir); end
      tick();
      checks++; if (a_ov !== 1'b1 || a_imm !== 64'h1) begin errors++; $display("FAIL skid_A: got ov=%b imm=%h want ov=1 imm=1", a_ov, a_imm); end
      checks++; if (a_ir !== 1'b1) begin errors++; $display("FAIL skid_ir1: got %b want 1", a_ir); end
      a_instr = 32'h00513823;   // B: sd imm=16
      tick();
      checks++; if (a_ir !== 1'b0) begin errors++; $display("FAIL skid_full_ir: got %b want 0", a_ir); end
      checks++; if (a_imm !== 64'h1 || a_fmt !== 3'd1) begin errors++; $display("FAIL skid_holdA: got imm=%h fmt=%0d want imm=1 fmt=1", a_imm, a_fmt); end
      a_instr = 32'h800000B7;   // C: lui, held by the source
      tick();
      checks++; if (a_ir !== 1'b0 || a_imm !== 64'h1) begin errors++; $display("FAIL skid_stall: got ir=%b imm=%h want ir=0 imm=1", a_ir, a_imm); end
      a_or = 1'b1;
      tick();
      checks++; if (a_ov !== 1'b1 || a_imm !== 64'h10 || a_fmt !== 3'd2) begin errors++; $display("FAIL skid_B: got ov=%b imm=%h fmt=%0d want ov=1 imm=10 fmt=2", a_ov, a_imm, a_fmt); end
      checks++; if (a_ir !== 1'b1) begin errors++; $display("FAIL skid_ir_back: got %b want 1", a_ir); end
      tick();
      checks++; if (a_ov !== 1'b1 || a_imm !== 64'hFFFFFFFF80000000 || a_fmt !== 3'd4) begin errors++; $display("FAIL skid_C: got ov=%b imm=%h fmt=%0d want ov=1 imm=ffffffff80000000 fmt=4", a_ov, a_imm, a_fmt); end
      a_iv = 1'b0;
      tick();
      checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL skid_empty: got %b want 0", a_ov); end
   endtask

   task automatic test_noskid();
      c_or    = 1'b0;
      c_iv    = 1'b1;
      c_instr = 32'h00100013;
      #1;
      checks++; if (c_ir !== 1'b1) begin errors++; $display("FAIL nsk_ir0: got %b want 1", c_ir); end
      tick();
      checks++; if (c_ov !== 1'b1 || c_imm !== 64'h1) begin errors++; $display("FAIL nsk_A: got ov=%b imm=%h want ov=1 imm=1", c_ov, c_imm); end
      checks++; if (c_ir !== 1'b0) begin errors++; $display("FAIL nsk_ir_stall: got %b want 0", c_ir); end
      c_instr = 32'h00513823;
      tick();
      checks++; if (c_imm !== 64'h1) begin errors++; $display("FAIL nsk_holdA: got %h want 1", c_imm); end
      c_or = 1'b1;
      #1;
      checks++; if (c_ir !== 1'b1) begin errors++; $display("FAIL nsk_ir_comb: got %b want 1", c_ir); end
      tick();
      checks++; if (c_imm !== 64'h10 || c_fmt !== 3'd2) begin errors++; $display("FAIL nsk_B: got imm=%h fmt=%0d want imm=10 fmt=2", c_imm, c_fmt); end
      c_instr = 32'h800000B7;
      c_or    = 1'b0;
      #1;
      checks++; if (c_ir !== 1'b0) begin errors++; $display("FAIL nsk_ir_drop: got %b want 0", c_ir); end
      c_or = 1'b1;
      #1;
      checks++; if (c_ir !== 1'b1) begin errors++; $display("FAIL nsk_ir_rise: got %b want 1", c_ir); end
      tick();
      checks++; if (c_imm !== 64'hFFFFFFFF80000000 || c_fmt !== 3'd4) begin errors++; $display("FAIL nsk_C: got imm=%h fmt=%0d want imm=ffffffff80000000 fmt=4", c_imm, c_fmt); end
      c_iv = 1'b0;
      tick();
      checks++; if (c_ov !== 1'b0) begin errors++; $display("FAIL nsk_empty: got %b want 0", c_ov); end
   endtask

   task automatic test_reset_midstream();
      a_or    = 1'b0;
      a_iv    = 1'b1;
      a_instr = 32'hFFFFFFFF;   // illegal, lands in output register
      tick();
      a_instr = 32'h00513823;   // lands in skid entry
      tick();
      a_iv = 1'b0;
      checks++; if (a_ir !== 1'b0) begin errors++; $display("FAIL mid_full_ir: got %b want 0", a_ir); end
      checks++; if (a_cnt !== 8'd2) begin errors++; $display("FAIL mid_cnt_pre: got %0d want 2", a_cnt); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL mid_ov: got %b want 0", a_ov); end
      checks++; if (a_cnt !== 8'd0) begin errors++; $display("FAIL mid_cnt: got %0d want 0", a_cnt); end
      checks++; if (a_imm !== 64'h0 || a_fmt !== 3'd0 || a_ill !== 1'b0) begin errors++; $display("FAIL mid_out: got imm=%h fmt=%0d ill=%b want 0 0 0", a_imm, a_fmt, a_ill); end
      checks++; if (a_ir !== 1'b1) begin errors++; $display("FAIL mid_ir: got %b want 1", a_ir); end
      checks++; if (b_cnt !== 8'd0) begin errors++; $display("FAIL mid_b_cnt: got %0d want 0", b_cnt); end
      a_or = 1'b1;
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL mid_ghost[%0d]: got ov=%b imm=%h want ov=0", i, a_ov, a_imm); end
      end
      a_iv    = 1'b1;
      a_instr = 32'h001000EF;
      tick();
      checks++; if (a_ov !== 1'b1 || a_imm !== 64'h800 || a_fmt !== 3'd5) begin errors++; $display("FAIL mid_new: got ov=%b imm=%h fmt=%0d want ov=1 imm=800 fmt=5", a_ov, a_imm, a_fmt); end
      a_iv = 1'b0;
      tick();
      checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL mid_end: got %b want 0", a_ov); end
   endtask

   initial begin
      rst_n = 1'b1;
      a_iv = 1'b0; a_or = 1'b0; a_instr = '0;
      b_iv = 1'b0; b_or = 1'b0; b_instr = '0;
      c_iv = 1'b0; c_or = 1'b0; c_instr = '0;
      #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      test_formats();
      test_illegal32();
      test_skid();
      test_noskid();
      test_reset_midstream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
